// File: rtl/matrix_mul_ctrl.sv
// matrix_mul_ctrl: grants the shared matrix_mul datapath to the matrix command port or
// the vertex port, counts its fixed latencies, and returns transformed vertices.
module matrix_mul_ctrl #(
   parameter int MAT_LAT = 17,
   parameter int VEC_LAT = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_mode,
   input  logic [31:0]  cmd_addr,
   input  logic         vtx_valid,
   output logic         vtx_ready,
   input  logic [31:0]  vtx_addr,
   output logic         vtx_out_valid,
   input  logic         vtx_out_ready,
   output logic [127:0] vtx_out_data,
   output logic         mm_en,
   output logic         mm_mul_type,
   output logic         mm_mode,
   output logic [31:0]  mm_addr,
   input  logic [127:0] mm_vector_in,
   input  logic         mm_write_en,
   output logic         mat_done,
   output logic         err,
   output logic         busy,
   output logic [2:0]   state_dbg
);
   localparam int CNT_W = $clog2(MAT_LAT);
   localparam logic [CNT_W-1:0] MAT_LAST = CNT_W'(MAT_LAT - 1);
   localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(VEC_LAT);

   typedef enum logic [2:0] {FLUSH, IDLE, MAT_RUN, VTX_RUN, VTX_OUT} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             last_vtx, last_vtx_nxt;
   logic             wrote, wrote_nxt;
   logic             mm_en_nxt, mm_mul_type_nxt, mm_mode_nxt;
   logic [31:0]      mm_addr_nxt;
   logic             mat_done_nxt, err_nxt, vtx_out_valid_nxt;
   logic [127:0]     vtx_out_data_nxt;

   // All three ports are valid/ready: a transfer happens in a cycle where both are high;
   // valid may drop while ready is low, and nothing is latched before the transfer.
   always_comb begin
      state_nxt         = state;
      cnt_nxt           = cnt;
      last_vtx_nxt      = last_vtx;
      wrote_nxt         = wrote;
      mm_en_nxt         = 1'b0;
      mm_mul_type_nxt   = mm_mul_type;
      mm_mode_nxt       = mm_mode;
      mm_addr_nxt       = mm_addr;
      mat_done_nxt      = 1'b0;
      err_nxt           = err;
      vtx_out_valid_nxt = vtx_out_valid;
      vtx_out_data_nxt  = vtx_out_data;
      cmd_ready         = 1'b0;
      vtx_ready         = 1'b0;
      busy              = (state != IDLE);
      state_dbg         = state;
      case (state)
         FLUSH: begin
            // the datapath has no reset, so let any in-flight op drain first
            cnt_nxt = cnt + 1'b1;
            if (cnt == MAT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         IDLE: begin
            cmd_ready = cmd_valid && (!vtx_valid || last_vtx);
            vtx_ready = vtx_valid && !cmd_ready;
            if (cmd_ready) begin
               state_nxt       = MAT_RUN;
               mm_en_nxt       = 1'b1;
               mm_mul_type_nxt = 1'b1;
               mm_mode_nxt     = cmd_mode;
               mm_addr_nxt     = cmd_addr;
               last_vtx_nxt    = 1'b0;
               cnt_nxt         = '0;
               wrote_nxt       = 1'b0;
            end else if (vtx_ready) begin
               state_nxt       = VTX_RUN;
               mm_en_nxt       = 1'b1;
               mm_mul_type_nxt = 1'b0;
               mm_mode_nxt     = 1'b0;
               mm_addr_nxt     = vtx_addr;
               last_vtx_nxt    = 1'b1;
               cnt_nxt         = '0;
               wrote_nxt       = 1'b0;
            end
         end
         MAT_RUN: begin
            cnt_nxt = cnt + 1'b1;
            if (mm_write_en) wrote_nxt = 1'b1;
            if (cnt == MAT_LAST) begin
               state_nxt    = IDLE;
               cnt_nxt      = '0;
               mat_done_nxt = 1'b1;
               if (!wrote && !mm_write_en) err_nxt = 1'b1;
            end
         end
         VTX_RUN: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == VEC_LAST) begin
               state_nxt         = VTX_OUT;
               cnt_nxt           = '0;
               vtx_out_data_nxt  = mm_vector_in;
               vtx_out_valid_nxt = 1'b1;
            end
         end
         VTX_OUT: begin
            if (vtx_out_ready) begin
               state_nxt         = IDLE;
               vtx_out_valid_nxt = 1'b0;
            end
         end
         default: state_nxt = FLUSH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FLUSH;
         cnt           <= '0;
         last_vtx      <= 1'b1;
         wrote         <= 1'b0;
         mm_en         <= 1'b0;
         mm_mul_type   <= 1'b0;
         mm_mode       <= 1'b0;
         mm_addr       <= '0;
         mat_done      <= 1'b0;
         err           <= 1'b0;
         vtx_out_valid <= 1'b0;
         vtx_out_data  <= '0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         last_vtx      <= last_vtx_nxt;
         wrote         <= wrote_nxt;
         mm_en         <= mm_en_nxt;
         mm_mul_type   <= mm_mul_type_nxt;
         mm_mode       <= mm_mode_nxt;
         mm_addr       <= mm_addr_nxt;
         mat_done      <= mat_done_nxt;
         err           <= err_nxt;
         vtx_out_valid <= vtx_out_valid_nxt;
         vtx_out_data  <= vtx_out_data_nxt;
      end
   end
endmodule

// File: tb/tb_matrix_mul_ctrl.sv
// tb_matrix_mul_ctrl: directed and randomized checks of matrix_mul_ctrl against a
// transaction-level timing model and a fixed-latency datapath model.
`timescale 1ns/1ps
module tb_matrix_mul_ctrl;
   localparam int MAT_LAT = 17;
   localparam int VEC_LAT = 8;
   localparam int NEVER = 32'h3fffffff;
   localparam logic [127:0] FIXED_VEC = 128'h3F800000_40000000_40400000_3F800000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0, cmd_mode = 1'b0;
   logic [31:0]  cmd_addr = '0, vtx_addr = '0;
   logic         vtx_valid = 1'b0, vtx_out_ready = 1'b0;
   logic         cmd_ready, vtx_ready, vtx_out_valid;
   logic [127:0] vtx_out_data;
   logic         mm_en, mm_mul_type, mm_mode, mat_done, err, busy;
   logic [31:0]  mm_addr;
   logic [127:0] mm_vector_in = '0;
   logic         mm_write_en = 1'b0;
   logic [2:0]   state_dbg;

   matrix_mul_ctrl #(.MAT_LAT(MAT_LAT), .VEC_LAT(VEC_LAT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_addr(cmd_addr),
      .vtx_valid(vtx_valid), .vtx_ready(vtx_ready), .vtx_addr(vtx_addr),
      .vtx_out_valid(vtx_out_valid), .vtx_out_ready(vtx_out_ready), .vtx_out_data(vtx_out_data),
      .mm_en(mm_en), .mm_mul_type(mm_mul_type), .mm_mode(mm_mode), .mm_addr(mm_addr),
      .mm_vector_in(mm_vector_in), .mm_write_en(mm_write_en),
      .mat_done(mat_done), .err(err), .busy(busy), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // datapath stand-in: write pulse at E+16, vector valid only at E+8
   int           e_cyc = -100;
   logic         e_mat = 1'b0;
   logic [127:0] dp_vec = '0;
   logic         dp_omit = 1'b0;
   always @(negedge clk) if (mm_en === 1'b1) begin e_cyc = cyc; e_mat = mm_mul_type; end
   always @(posedge clk) begin
      #1;
      mm_write_en  = e_mat && !dp_omit && (cyc == e_cyc + MAT_LAT - 1);
      mm_vector_in = (!e_mat && cyc == e_cyc + VEC_LAT) ? dp_vec : ~dp_vec;
   end

   int checks = 0, errors = 0;
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference model state (transaction level: cycle numbers of expected events)
   int           idle_from = NEVER, en_at = -1, done_at = -1, out_from = NEVER;
   logic         out_pend = 1'b0, last_vtx = 1'b1, err_exp = 1'b0, op_live = 1'b0, op_omit = 1'b0;
   logic [31:0]  exp_addr = '0;
   logic         exp_mode = 1'b0, exp_type = 1'b0;
   logic [127:0] exp_q[$];
   logic         omit_we = 1'b0, fixed_en = 1'b0;

   // observations used by directed step checks
   int           last_en_cyc = -1, last_done_cyc = -1, last_acc_cyc = -1, hs_cyc = -1;
   int           ov_rise_cyc = -1, en_count = 0;
   logic [127:0] ov_rise_data = '0;
   logic         ov_prev = 1'b0, obs_busy = 1'b0;
   logic         grant_log[$];

   task automatic tick();
      logic idle, exp_cr, exp_vr, exp_ov;
      logic [127:0] v;
      int n;
      #2;
      n = cyc;
      if (n == done_at && op_omit) err_exp = 1'b1;
      idle   = (n >= idle_from);
      exp_ov = out_pend && (n >= out_from);
      exp_cr = idle && cmd_valid && (!vtx_valid || last_vtx);
      exp_vr = idle && vtx_valid && !exp_cr;
      chk("busy", busy, !idle);
      chk("cmd_ready", cmd_ready, exp_cr);
      chk("vtx_ready", vtx_ready, exp_vr);
      chk("mm_en", mm_en, n == en_at);
      chk("mat_done", mat_done, n == done_at);
      chk("err", err, err_exp);
      chk("vtx_out_valid", vtx_out_valid, exp_ov);
      if (exp_ov) chk("vtx_out_data", vtx_out_data, exp_q[0]);
      if (op_live && !idle && n >= en_at) begin
         chk("mm_addr", mm_addr, exp_addr);
         chk("mm_mode", mm_mode, exp_mode);
         chk("mm_mul_type", mm_mul_type, exp_type);
      end
      obs_busy = busy;
      if (mm_en) begin last_en_cyc = n; en_count++; end
      if (mat_done) last_done_cyc = n;
      if (cmd_valid && cmd_ready) begin last_acc_cyc = n; grant_log.push_back(1'b0); end
      if (vtx_valid && vtx_ready) begin last_acc_cyc = n; grant_log.push_back(1'b1); end
      if (vtx_out_valid && vtx_out_ready) hs_cyc = n;
      if (vtx_out_valid && !ov_prev) begin ov_rise_cyc = n; ov_rise_data = vtx_out_data; end
      ov_prev = vtx_out_valid;
      if (rst) begin
         idle_from = n + MAT_LAT + 1;
         en_at = -1; done_at = -1; out_pend = 1'b0; out_from = NEVER;
         err_exp = 1'b0; last_vtx = 1'b1; op_live = 1'b0;
         exp_q.delete();
      end else begin
         if (exp_ov && vtx_out_ready) begin
            void'(exp_q.pop_front());
            out_pend  = 1'b0;
            idle_from = n + 1;
         end
         if (exp_cr) begin
            en_at = n + 1; done_at = n + 1 + MAT_LAT; idle_from = n + 1 + MAT_LAT;
            exp_addr = cmd_addr; exp_mode = cmd_mode; exp_type = 1'b1;
            op_omit = omit_we; dp_omit = omit_we; last_vtx = 1'b0; op_live = 1'b1;
         end else if (exp_vr) begin
            v = fixed_en ? FIXED_VEC : {$urandom, $urandom, $urandom, $urandom};
            dp_vec = v;
            exp_q.push_back(v);
            en_at = n + 1; idle_from = NEVER; out_pend = 1'b1; out_from = n + VEC_LAT + 2;
            exp_addr = vtx_addr; exp_mode = 1'b0; exp_type = 1'b0;
            op_omit = 1'b0; last_vtx = 1'b1; op_live = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int flush_len, g0, en0;
      // reset and flush window
      repeat (2) begin @(posedge clk); #1; end
      tick();
      rst = 1'b0;
      chk("rst_vtx_out_data", vtx_out_data, 128'h0);
      chk("rst_err", err, 1'b0);
      flush_len = 0;
      for (int i = 0; i < 25; i++) begin tick(); if (obs_busy) flush_len++; end
      chk("flush_len", flush_len, 17);

      // single matrix command
      cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_addr = 32'h100;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("mat_en_lat", last_en_cyc - last_acc_cyc, 1);
      chk("mat_done_lat", last_done_cyc - last_en_cyc, MAT_LAT);
      chk("mat_err", err, 1'b0);

      // single vertex with a known vector
      fixed_en = 1'b1; vtx_out_ready = 1'b1;
      vtx_valid = 1'b1; vtx_addr = 32'h40;
      tick();
      vtx_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      fixed_en = 1'b0;
      chk("vtx_valid_lat", ov_rise_cyc - last_en_cyc, VEC_LAT + 1);
      chk("vtx_data", ov_rise_data, FIXED_VEC);

      // both requesters held: grants must alternate starting with the command port
      g0 = grant_log.size();
      cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_addr = 32'h200;
      vtx_valid = 1'b1; vtx_addr = 32'h300;
      for (int i = 0; i < 80; i++) tick();
      cmd_valid = 1'b0; vtx_valid = 1'b0;
      chk("alt_grant_count", grant_log.size() - g0 >= 4, 1'b1);
      for (int i = 0; i < 4; i++)
         if (g0 + i < grant_log.size()) chk("alt_grant", grant_log[g0 + i], i % 2);
      for (int i = 0; i < 25; i++) tick();

      // output stall with a command waiting
      vtx_out_ready = 1'b0;
      vtx_valid = 1'b1; vtx_addr = 32'h44;
      tick();
      vtx_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_addr = 32'h500;
      en0 = en_count;
      for (int i = 0; i < 10; i++) tick();
      chk("stall_no_en", en_count - en0, 0);
      chk("stall_valid", vtx_out_valid, 1'b1);
      vtx_out_ready = 1'b1;
      tick();
      tick();
      cmd_valid = 1'b0;
      chk("cmd_after_hs", last_acc_cyc - hs_cyc, 1);
      for (int i = 0; i < 20; i++) tick();

      // missing write pulse sets sticky err; reset mid-vertex clears it
      omit_we = 1'b1;
      cmd_valid = 1'b1; cmd_addr = 32'h600;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 18; i++) tick();
      omit_we = 1'b0;
      chk("err_set", err, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      chk("err_sticky", err, 1'b1);
      vtx_valid = 1'b1; vtx_addr = 32'h80;
      tick();
      vtx_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_err", err, 1'b0);
      chk("rst_mid_out_valid", vtx_out_valid, 1'b0);
      chk("rst_mid_busy", busy, 1'b1);
      for (int i = 0; i < 20; i++) tick();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         cmd_valid     = 1'($urandom_range(0, 1));
         cmd_mode      = 1'($urandom_range(0, 1));
         cmd_addr      = $urandom;
         vtx_valid     = 1'($urandom_range(0, 1));
         vtx_addr      = $urandom;
         vtx_out_ready = ($urandom_range(0, 3) != 0);
         omit_we       = ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
